// File: rtl/riscv_irq_stimulus_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : riscv_irq_stimulus_gen                                   |
// | Purpose : Interrupt source (random / periodic / PC-trigger) with   |
// |           ack timeout. Define IRQ_GEN_PC_TRIGGER_EN for mode 11.   |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module riscv_irq_stimulus_gen #(
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int unsigned MIN_GAP     = 8,
  parameter int unsigned GAP_RND_W   = 6,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  mode_i,
  input  logic [15:0] period_i,
  input  logic [4:0]  irq_id_cfg_i,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_trig_i,
  input  logic        irq_ack_i,
  output logic        irq_rnd_o,
  output logic [4:0]  irq_id_rnd_o,
  output logic        busy_o,
  output logic        lost_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ASSERT = 2'd2
  } state_e;

  localparam logic [1:0]  c_MODE_OFF    = 2'b00;
  localparam logic [1:0]  c_MODE_RND    = 2'b01;
  localparam logic [1:0]  c_MODE_PER    = 2'b10;
  localparam logic [1:0]  c_MODE_PC     = 2'b11;
  localparam logic [31:0] c_SEED        = (LFSR_SEED == 32'd0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] c_TAPS        = 32'h8020_0003;
  localparam logic [15:0] c_MIN_GAP     = 16'(MIN_GAP);
  localparam logic [15:0] c_ACK_TIMEOUT = 16'(ACK_TIMEOUT);

  state_e      r_state, w_state_d;
  logic [31:0] r_lfsr, w_lfsr_d;
  logic [15:0] r_cnt, w_cnt_d, r_ack_cnt, w_ack_cnt_d;
  logic [1:0]  r_mode, w_mode_d;
  logic        r_irq, w_irq_d, r_lost, w_lost_d, r_armed, w_armed_d;
  logic [4:0]  r_id, w_id_d;
  logic [1:0]  w_mode;
  logic        w_pc_hit, w_pc_miss, w_entry, w_cfg_ok;
  logic [4:0]  w_idx, w_rnd_id, w_cfg_id;
  logic [15:0] w_gap_rnd, w_period;

`ifdef IRQ_GEN_PC_TRIGGER_EN
  assign w_mode    = mode_i;
  assign w_pc_hit  = pc_valid_i && (pc_i == pc_trig_i);
  assign w_pc_miss = pc_valid_i && (pc_i != pc_trig_i);
`else
  // Mode 11 folds onto "off" so the LFSR freezes and nothing is raised.
  logic w_unused_pc;
  assign w_unused_pc = ^{pc_valid_i, pc_i, pc_trig_i};
  assign w_mode      = (mode_i == c_MODE_PC) ? c_MODE_OFF : mode_i;
  assign w_pc_hit    = 1'b0;
  assign w_pc_miss   = 1'b0;
`endif

  always_comb begin
    w_idx = r_lfsr[4:0];
    if (w_idx >= 5'd18) w_idx = w_idx - 5'd18;
    case (w_idx)
      5'd0:    w_rnd_id = 5'd3;
      5'd1:    w_rnd_id = 5'd7;
      5'd2:    w_rnd_id = 5'd11;
      default: w_rnd_id = w_idx + 5'd13;
    endcase
  end

  assign w_cfg_ok  = (irq_id_cfg_i == 5'd3) || (irq_id_cfg_i == 5'd7) || (irq_id_cfg_i == 5'd11) ||
                     ((irq_id_cfg_i >= 5'd16) && (irq_id_cfg_i <= 5'd30));
  assign w_cfg_id  = w_cfg_ok ? irq_id_cfg_i : 5'd7;
  assign w_gap_rnd = c_MIN_GAP + 16'(r_lfsr[GAP_RND_W-1:0]);
  assign w_period  = (period_i == 16'd0) ? 16'd1 : period_i;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_ack_cnt_d = r_ack_cnt;
    w_mode_d    = r_mode;
    w_irq_d     = r_irq;
    w_id_d      = r_id;
    w_lost_d    = 1'b0;
    w_armed_d   = r_armed;
    w_entry     = 1'b0;
    w_lfsr_d    = (w_mode != c_MODE_OFF) ? ((r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : 32'd0)) : r_lfsr;

    case (r_state)
      IDLE: begin
        w_mode_d = w_mode;
        if (w_mode == c_MODE_RND) begin
          w_cnt_d   = w_gap_rnd;
          w_state_d = COUNT;
        end else if (w_mode == c_MODE_PER) begin
          w_cnt_d   = w_period;
          w_state_d = COUNT;
        end else if (w_mode == c_MODE_PC) begin
          if (r_armed && w_pc_hit) w_entry   = 1'b1;
          else if (w_pc_miss)      w_armed_d = 1'b1;
        end
      end
      COUNT: begin
        if (w_mode != r_mode)     w_state_d = IDLE;
        else if (r_cnt == 16'd1)  w_entry   = 1'b1;
        else                      w_cnt_d   = r_cnt - 16'd1;
      end
      ASSERT: begin
        if (w_mode != r_mode) begin
          w_state_d = IDLE;
          w_irq_d   = 1'b0;
        end else if (irq_ack_i || (r_ack_cnt == c_ACK_TIMEOUT - 16'd1)) begin
          // An ack arriving on the timeout cycle takes precedence: no loss reported.
          w_irq_d  = 1'b0;
          w_lost_d = !irq_ack_i;
          if (r_mode == c_MODE_PC) begin
            w_state_d = IDLE;
            w_armed_d = 1'b0;
          end else begin
            w_state_d = COUNT;
            w_cnt_d   = (r_mode == c_MODE_RND) ? w_gap_rnd : w_period;
          end
        end else begin
          w_ack_cnt_d = r_ack_cnt + 16'd1;
        end
      end
      default: w_state_d = IDLE;
    endcase

    if (w_entry) begin
      w_state_d   = ASSERT;
      w_irq_d     = 1'b1;
      w_id_d      = (w_mode == c_MODE_RND) ? w_rnd_id : w_cfg_id;
      w_ack_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_lfsr    <= c_SEED;
      r_cnt     <= 16'd0;
      r_ack_cnt <= 16'd0;
      r_mode    <= c_MODE_OFF;
      r_irq     <= 1'b0;
      r_id      <= 5'd0;
      r_lost    <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_lfsr    <= w_lfsr_d;
      r_cnt     <= w_cnt_d;
      r_ack_cnt <= w_ack_cnt_d;
      r_mode    <= w_mode_d;
      r_irq     <= w_irq_d;
      r_id      <= w_id_d;
      r_lost    <= w_lost_d;
      r_armed   <= w_armed_d;
    end
  end

  assign irq_rnd_o    = r_irq;
  assign irq_id_rnd_o = r_id;
  assign lost_o       = r_lost;
  assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire
